// File: rtl/vx_operands_serializer_pkg.sv
// Shared state type and sizing helpers for the operand serializer.
package vx_operands_serializer_pkg;

  localparam int unsigned DefaultLanesIn = 4;
  localparam int unsigned DefaultDataW   = 32;
  localparam int unsigned DefaultMetaW   = 64;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } ser_state_e;

  function automatic int unsigned calc_num_pids(input int unsigned lanes_in,
                                                input int unsigned lanes_out);
    return (lanes_out == 0) ? 1 : lanes_in / lanes_out;
  endfunction

  function automatic int unsigned calc_pid_w(input int unsigned lanes_in,
                                             input int unsigned lanes_out);
    int unsigned n;
    n = calc_num_pids(lanes_in, lanes_out);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_operands_serializer_if.sv
// Wide-in / narrow-out operand stream bundle; slave = serializer, master = its environment.
interface vx_operands_serializer_if #(
  parameter int unsigned NUM_LANES_IN  = 4,
  parameter int unsigned NUM_LANES_OUT = 1,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned META_W        = 64,
  parameter int unsigned PID_W         = 2
);

  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_LANES_IN-1:0]          in_tmask;
  logic [NUM_LANES_IN*DATA_W-1:0]   in_rs1_data;
  logic [NUM_LANES_IN*DATA_W-1:0]   in_rs2_data;
  logic [NUM_LANES_IN*DATA_W-1:0]   in_rs3_data;
  logic [META_W-1:0]                in_meta;

  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_LANES_OUT-1:0]         out_tmask;
  logic [NUM_LANES_OUT*DATA_W-1:0]  out_rs1_data;
  logic [NUM_LANES_OUT*DATA_W-1:0]  out_rs2_data;
  logic [NUM_LANES_OUT*DATA_W-1:0]  out_rs3_data;
  logic [META_W-1:0]                out_meta;
  logic [PID_W-1:0]                 out_pid;
  logic                             out_sop;
  logic                             out_eop;

  modport master (
    output in_valid, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, in_meta, out_ready,
    input  in_ready, out_valid, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
           out_meta, out_pid, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, in_meta, out_ready,
    output in_ready, out_valid, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
           out_meta, out_pid, out_sop, out_eop
  );

endinterface

// File: rtl/vx_operands_group_scan.sv
// Priority scan over per-group "any lane active" flags: lowest active group, lowest active
// group above pid_i, and whether nothing active remains above pid_i.
module vx_operands_group_scan #(
  parameter int unsigned NUM_PIDS = 4,
  parameter int unsigned PID_W    = 2
) (
  input  logic [NUM_PIDS-1:0] any_i,
  input  logic [PID_W-1:0]    pid_i,
  output logic [PID_W-1:0]    first_o,
  output logic [PID_W-1:0]    next_o,
  output logic                last_o
);

  // Walk downwards so the lowest matching group is the final writer.
  always_comb begin
    first_o = '0;
    next_o  = pid_i;
    last_o  = 1'b1;
    for (int g = int'(NUM_PIDS) - 1; g >= 0; g--) begin
      if (any_i[g]) begin
        first_o = PID_W'(g);
      end
      if (any_i[g] && (g > int'(pid_i))) begin
        next_o = PID_W'(g);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vx_operands_serializer.sv
// Serializes one wide operand packet into NUM_LANES_IN/NUM_LANES_OUT narrow beats.
// Define VX_OPERANDS_SKIP_EMPTY_EN to skip groups whose thread-mask slice is all zero.
module vx_operands_serializer
  import vx_operands_serializer_pkg::*;
#(
  parameter int unsigned NUM_LANES_IN  = DefaultLanesIn,
  parameter int unsigned NUM_LANES_OUT = 1,
  parameter int unsigned DATA_W        = DefaultDataW,
  parameter int unsigned META_W        = DefaultMetaW
) (
  input logic                     clk,
  input logic                     reset,
  vx_operands_serializer_if.slave bus_io
);

  localparam int unsigned NUM_PIDS = calc_num_pids(NUM_LANES_IN, NUM_LANES_OUT);
  localparam int unsigned PID_W    = calc_pid_w(NUM_LANES_IN, NUM_LANES_OUT);
  localparam int unsigned SliceW   = NUM_LANES_OUT * DATA_W;
  localparam int unsigned WideW    = NUM_LANES_IN * DATA_W;

  if (NUM_LANES_OUT == 0 || (NUM_LANES_IN % NUM_LANES_OUT) != 0) begin : g_bad_cfg
    $error("vx_operands_serializer: NUM_LANES_OUT must divide NUM_LANES_IN");
  end

  ser_state_e              state_q, state_d;
  logic [PID_W-1:0]        pid_q, pid_d;
  logic [NUM_LANES_IN-1:0] tmask_q;
  logic [WideW-1:0]        rs1_q, rs2_q, rs3_q;
  logic [META_W-1:0]       meta_q;

  logic             busy;
  logic             in_ready;
  logic             accept;
  logic             out_sop;
  logic             out_eop;
  logic             last_grp;
  logic [PID_W-1:0] first_in;
  logic [PID_W-1:0] first_held;
  logic [PID_W-1:0] next_pid;

`ifdef VX_OPERANDS_SKIP_EMPTY_EN
  logic [NUM_PIDS-1:0] any_in;
  logic [NUM_PIDS-1:0] any_held;
  logic [PID_W-1:0]    unused_in_next;
  logic                unused_in_last;

  for (genvar g = 0; g < NUM_PIDS; g++) begin : g_any
    assign any_in[g]   = |bus_io.in_tmask[g*NUM_LANES_OUT +: NUM_LANES_OUT];
    assign any_held[g] = |tmask_q[g*NUM_LANES_OUT +: NUM_LANES_OUT];
  end

  // Incoming packet only needs its first group; the held packet drives pid stepping and eop.
  vx_operands_group_scan #(
    .NUM_PIDS (NUM_PIDS),
    .PID_W    (PID_W)
  ) u_scan_in (
    .any_i   (any_in),
    .pid_i   ('0),
    .first_o (first_in),
    .next_o  (unused_in_next),
    .last_o  (unused_in_last)
  );

  vx_operands_group_scan #(
    .NUM_PIDS (NUM_PIDS),
    .PID_W    (PID_W)
  ) u_scan_held (
    .any_i   (any_held),
    .pid_i   (pid_q),
    .first_o (first_held),
    .next_o  (next_pid),
    .last_o  (last_grp)
  );
`else
  assign first_in   = '0;
  assign first_held = '0;
  assign next_pid   = pid_q + PID_W'(1);
  assign last_grp   = (pid_q == PID_W'(NUM_PIDS - 1));
`endif

  assign busy     = (state_q == StBusy);
  assign out_sop  = busy & (pid_q == first_held);
  assign out_eop  = busy & last_grp;
  // Depends on out_ready only, so the last beat and the next packet can cross in one cycle.
  assign in_ready = ~busy | (bus_io.out_ready & out_eop);
  assign accept   = bus_io.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          pid_d   = first_in;
        end
      end
      StBusy: begin
        if (accept) begin
          pid_d = first_in;
        end else if (bus_io.out_ready) begin
          if (last_grp) begin
            state_d = StIdle;
          end else begin
            pid_d = next_pid;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
    end
  end

  // Payload is qualified by state_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tmask_q <= bus_io.in_tmask;
      rs1_q   <= bus_io.in_rs1_data;
      rs2_q   <= bus_io.in_rs2_data;
      rs3_q   <= bus_io.in_rs3_data;
      meta_q  <= bus_io.in_meta;
    end
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.out_valid    = busy;
  assign bus_io.out_tmask    = tmask_q[int'(pid_q)*NUM_LANES_OUT +: NUM_LANES_OUT];
  assign bus_io.out_rs1_data = rs1_q[int'(pid_q)*SliceW +: SliceW];
  assign bus_io.out_rs2_data = rs2_q[int'(pid_q)*SliceW +: SliceW];
  assign bus_io.out_rs3_data = rs3_q[int'(pid_q)*SliceW +: SliceW];
  assign bus_io.out_meta     = meta_q;
  assign bus_io.out_pid      = pid_q;
  assign bus_io.out_sop      = out_sop;
  assign bus_io.out_eop      = out_eop;

endmodule

// File: tb/tb_vx_operands_serializer.sv
// Bench for vx_operands_serializer: directed 4:1, table 8:2, NUM_PIDS=1 and random 8:2 runs.
module tb_vx_operands_serializer;
  import vx_operands_serializer_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned MW  = 16;
  localparam int unsigned PWA = calc_pid_w(4, 1);
  localparam int unsigned PWB = calc_pid_w(8, 2);
  localparam int unsigned PWC = calc_pid_w(2, 2);
`ifdef VX_OPERANDS_SKIP_EMPTY_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic clk;
  logic reset;

  vx_operands_serializer_if #(.NUM_LANES_IN(4), .NUM_LANES_OUT(1), .DATA_W(DW), .META_W(MW),
                              .PID_W(PWA)) a_if ();
  vx_operands_serializer_if #(.NUM_LANES_IN(8), .NUM_LANES_OUT(2), .DATA_W(DW), .META_W(MW),
                              .PID_W(PWB)) b_if ();
  vx_operands_serializer_if #(.NUM_LANES_IN(2), .NUM_LANES_OUT(2), .DATA_W(DW), .META_W(MW),
                              .PID_W(PWC)) c_if ();

  vx_operands_serializer #(.NUM_LANES_IN(4), .NUM_LANES_OUT(1), .DATA_W(DW), .META_W(MW))
    u_dut_a (.clk(clk), .reset(reset), .bus_io(a_if.slave));
  vx_operands_serializer #(.NUM_LANES_IN(8), .NUM_LANES_OUT(2), .DATA_W(DW), .META_W(MW))
    u_dut_b (.clk(clk), .reset(reset), .bus_io(b_if.slave));
  vx_operands_serializer #(.NUM_LANES_IN(2), .NUM_LANES_OUT(2), .DATA_W(DW), .META_W(MW))
    u_dut_c (.clk(clk), .reset(reset), .bus_io(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- 4:1 instance ----------------
  typedef struct {
    logic [3:0]  tm;
    logic [63:0] r1, r2, r3;
    logic [15:0] meta;
  } pkt_a_t;
  typedef struct packed {
    logic        v;
    logic [1:0]  pid;
    logic        sop, eop, tm;
    logic [15:0] r1, r2, r3, meta;
  } beat_a_t;
  pkt_a_t pa[4];

  function automatic beat_a_t a_act();
    beat_a_t b;
    b.v = a_if.out_valid; b.pid = a_if.out_pid; b.sop = a_if.out_sop; b.eop = a_if.out_eop;
    b.tm = a_if.out_tmask[0]; b.r1 = a_if.out_rs1_data; b.r2 = a_if.out_rs2_data;
    b.r3 = a_if.out_rs3_data; b.meta = a_if.out_meta;
    return b;
  endfunction

  function automatic beat_a_t a_exp(input int p, input int pid);
    beat_a_t b;
    b.v = 1'b1; b.pid = 2'(pid); b.sop = (pid == 0); b.eop = (pid == 3);
    b.tm = pa[p].tm[pid]; b.r1 = pa[p].r1[pid*16 +: 16]; b.r2 = pa[p].r2[pid*16 +: 16];
    b.r3 = pa[p].r3[pid*16 +: 16]; b.meta = pa[p].meta;
    return b;
  endfunction

  task automatic a_drive(input bit v, input int p, input bit ordy);
    a_if.in_valid = v; a_if.in_tmask = pa[p].tm; a_if.in_rs1_data = pa[p].r1;
    a_if.in_rs2_data = pa[p].r2; a_if.in_rs3_data = pa[p].r3; a_if.in_meta = pa[p].meta;
    a_if.out_ready = ordy;
  endtask

  task automatic a_check(input string tag, input bit exp_v, input int p, input int pid,
                         input bit exp_ir);
    if (exp_v) chk({tag, "_beat"}, 128'(a_act()), 128'(a_exp(p, pid)));
    else chk({tag, "_idle"}, 128'(a_if.out_valid), 128'(1'b0));
    chk({tag, "_in_ready"}, 128'(a_if.in_ready), 128'(exp_ir));
  endtask

  typedef struct {
    bit v; int pkt; bit ordy; bit exp_v; int exp_pkt; int exp_pid; bit exp_ir;
  } step_t;
  step_t steps[12];

  // ---------------- 8:2 instance ----------------
  typedef struct packed {
    logic [1:0]  pid;
    logic        sop, eop;
    logic [1:0]  tm;
    logic [31:0] r1, r2, r3;
    logic [15:0] meta;
  } beat_b_t;
  beat_b_t bq[$];

  typedef struct {
    logic [7:0] tm;
    int         nb;
    int         pid;
    logic [1:0] first_tm;
  } vec_b_t;
  vec_b_t vb[6];

  function automatic beat_b_t b_act();
    beat_b_t b;
    b.pid = b_if.out_pid; b.sop = b_if.out_sop; b.eop = b_if.out_eop; b.tm = b_if.out_tmask;
    b.r1 = b_if.out_rs1_data; b.r2 = b_if.out_rs2_data; b.r3 = b_if.out_rs3_data;
    b.meta = b_if.out_meta;
    return b;
  endfunction

  // Reference: list the groups to emit, then cut one beat per listed group.
  task automatic b_push(input logic [7:0] tm, input logic [127:0] r1, input logic [127:0] r2,
                        input logic [127:0] r3, input logic [15:0] meta);
    int grp[$];
    beat_b_t bt;
    for (int g = 0; g < 4; g++) begin
      if (!Skip || tm[g*2 +: 2] != 2'b00) grp.push_back(g);
    end
    if (grp.size() == 0) grp.push_back(0);
    foreach (grp[i]) begin
      bt.pid = 2'(grp[i]); bt.sop = (i == 0); bt.eop = (i == grp.size() - 1);
      bt.tm = tm[grp[i]*2 +: 2]; bt.r1 = r1[grp[i]*32 +: 32]; bt.r2 = r2[grp[i]*32 +: 32];
      bt.r3 = r3[grp[i]*32 +: 32]; bt.meta = meta;
      bq.push_back(bt);
    end
  endtask

  task automatic b_drive(input bit v, input logic [7:0] tm, input logic [127:0] r1,
                         input logic [127:0] r2, input logic [127:0] r3, input logic [15:0] meta);
    b_if.in_valid = v; b_if.in_tmask = tm; b_if.in_rs1_data = r1; b_if.in_rs2_data = r2;
    b_if.in_rs3_data = r3; b_if.in_meta = meta;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r1, r2, r3;
    logic [7:0]   tm;
    logic [15:0]  meta;
    logic [31:0]  c_r1, c_r2, c_r3;
    int           nb;
    bit           done, exp_ir, fire_in, hold;

    reset = 1'b0;
    a_drive(1'b0, 0, 1'b0);
    b_drive(1'b0, '0, '0, '0, '0, '0);
    b_if.out_ready = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_tmask = '0; c_if.in_rs1_data = '0; c_if.in_rs2_data = '0;
    c_if.in_rs3_data = '0; c_if.in_meta = '0; c_if.out_ready = 1'b1;

    for (int p = 0; p < 4; p++) begin
      pa[p].tm = 4'hF;
      for (int k = 0; k < 4; k++) begin
        pa[p].r1[k*16 +: 16] = 16'(16'h1000 * (p + 1) + k);
        pa[p].r2[k*16 +: 16] = 16'(16'h1000 * (p + 1) + k) ^ 16'h5A5A;
        pa[p].r3[k*16 +: 16] = 16'(16'h1000 * (p + 1) + k + 16'h0100);
      end
      pa[p].meta = 16'(16'hA000 + p);
    end

    steps[0]  = '{1, 0, 1, 0, 0, 0, 1};
    steps[1]  = '{1, 1, 1, 1, 0, 0, 0};
    steps[2]  = '{1, 1, 1, 1, 0, 1, 0};
    steps[3]  = '{1, 1, 1, 1, 0, 2, 0};
    steps[4]  = '{1, 1, 1, 1, 0, 3, 1};
    steps[5]  = '{0, 1, 1, 1, 1, 0, 0};
    steps[6]  = '{0, 1, 0, 1, 1, 1, 0};
    steps[7]  = '{0, 1, 0, 1, 1, 1, 0};
    steps[8]  = '{0, 1, 1, 1, 1, 1, 0};
    steps[9]  = '{0, 1, 1, 1, 1, 2, 0};
    steps[10] = '{0, 1, 1, 1, 1, 3, 1};
    steps[11] = '{0, 1, 1, 0, 0, 0, 1};

    if (Skip) begin
      vb[0] = '{8'b0011_0000, 1, 2, 2'b11};
      vb[1] = '{8'b0000_0000, 1, 0, 2'b00};
      vb[2] = '{8'b1111_1111, 4, 0, 2'b11};
      vb[3] = '{8'b1000_0001, 2, 0, 2'b01};
      vb[4] = '{8'b0100_0000, 1, 3, 2'b01};
      vb[5] = '{8'b0000_1100, 1, 1, 2'b11};
    end else begin
      vb[0] = '{8'b0011_0000, 4, 0, 2'b00};
      vb[1] = '{8'b0000_0000, 4, 0, 2'b00};
      vb[2] = '{8'b1111_1111, 4, 0, 2'b11};
      vb[3] = '{8'b1000_0001, 4, 0, 2'b01};
      vb[4] = '{8'b0100_0000, 4, 0, 2'b00};
      vb[5] = '{8'b0000_1100, 4, 0, 2'b00};
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 128'(a_if.out_valid), 128'(1'b0));
    chk("rst_a_in_ready", 128'(a_if.in_ready), 128'(1'b1));
    chk("rst_a_sop_eop", 128'({a_if.out_sop, a_if.out_eop}), 128'(2'b00));
    chk("rst_b_valid", 128'(b_if.out_valid), 128'(1'b0));
    chk("rst_b_in_ready", 128'(b_if.in_ready), 128'(1'b1));
    chk("rst_c_valid", 128'(c_if.out_valid), 128'(1'b0));
    reset = 1'b1;

    // 4:1 back-to-back then out_ready 1,0,0,1
    foreach (steps[s]) begin
      @(posedge clk); #1;
      a_drive(steps[s].v, steps[s].pkt, steps[s].ordy);
      @(negedge clk);
      a_check($sformatf("a_step%0d", s), steps[s].exp_v, steps[s].exp_pkt, steps[s].exp_pid,
              steps[s].exp_ir);
    end

    // Reset asserted while pid 1 is on the output
    @(posedge clk); #1; a_drive(1'b1, 2, 1'b1);
    @(posedge clk); #1; a_drive(1'b0, 2, 1'b1);
    @(negedge clk); a_check("a_rst_pid0", 1'b1, 2, 0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); a_check("a_rst_pid1", 1'b1, 2, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("a_rst_mid_valid", 128'(a_if.out_valid), 128'(1'b0));
    chk("a_rst_mid_in_ready", 128'(a_if.in_ready), 128'(1'b1));
    chk("a_rst_mid_sop_eop", 128'({a_if.out_sop, a_if.out_eop}), 128'(2'b00));
    @(posedge clk); #1;
    chk("a_rst_hold_valid", 128'(a_if.out_valid), 128'(1'b0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("a_rst_no_replay", 128'(a_if.out_valid), 128'(1'b0));
    a_drive(1'b1, 3, 1'b1);
    @(posedge clk); #1; a_drive(1'b0, 3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); a_check($sformatf("a_post_rst%0d", k), 1'b1, 3, k, (k == 3));
      @(posedge clk); #1;
    end
    @(negedge clk); a_check("a_post_rst_idle", 1'b0, 0, 0, 1'b1);

    // NUM_PIDS=1: one beat per packet, full throughput
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      c_if.in_valid = (s < 3);
      c_if.in_tmask = 2'(s + 1);
      c_if.in_rs1_data = 32'(32'h0C01_0000 + s); c_if.in_rs2_data = 32'(32'h0C02_0000 + s);
      c_if.in_rs3_data = 32'(32'h0C03_0000 + s); c_if.in_meta = 16'(16'hC000 + s);
      @(negedge clk);
      chk($sformatf("c_in_ready%0d", s), 128'(c_if.in_ready), 128'(1'b1));
      if (s == 0 || s == 4) begin
        chk($sformatf("c_idle%0d", s), 128'(c_if.out_valid), 128'(1'b0));
      end else begin
        c_r1 = 32'(32'h0C01_0000 + s - 1); c_r2 = 32'(32'h0C02_0000 + s - 1);
        c_r3 = 32'(32'h0C03_0000 + s - 1);
        chk($sformatf("c_beat%0d", s),
            128'({c_if.out_valid, c_if.out_pid, c_if.out_sop, c_if.out_eop, c_if.out_tmask,
                  c_if.out_rs1_data, c_if.out_rs2_data, c_if.out_rs3_data, c_if.out_meta}),
            128'({1'b1, 1'b0, 1'b1, 1'b1, 2'(s), c_r1, c_r2, c_r3, 16'(16'hC000 + s - 1)}));
      end
    end

    // 8:2 table of mask patterns
    b_if.out_ready = 1'b1;
    foreach (vb[i]) begin
      for (int k = 0; k < 8; k++) begin
        r1[k*16 +: 16] = 16'(16'h3000 + i * 16 + k);
        r2[k*16 +: 16] = 16'(16'h4000 + i * 16 + k);
        r3[k*16 +: 16] = 16'(16'h5000 + i * 16 + k);
      end
      @(posedge clk); #1; b_drive(1'b1, vb[i].tm, r1, r2, r3, 16'(16'hB000 + i));
      @(posedge clk); #1; b_if.in_valid = 1'b0;
      nb = 0; done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        @(negedge clk);
        if (b_if.out_valid) begin
          if (nb == 0) begin
            chk($sformatf("b_tab%0d_pid", i), 128'(b_if.out_pid), 128'(vb[i].pid));
            chk($sformatf("b_tab%0d_tmask", i), 128'(b_if.out_tmask), 128'(vb[i].first_tm));
            chk($sformatf("b_tab%0d_sop", i), 128'(b_if.out_sop), 128'(1'b1));
            chk($sformatf("b_tab%0d_rs1", i), 128'(b_if.out_rs1_data),
                128'(r1[vb[i].pid*32 +: 32]));
          end
          nb++;
          if (b_if.out_eop) done = 1'b1;
        end
        if (!done) begin
          @(posedge clk); #1;
        end
      end
      chk($sformatf("b_tab%0d_eop_seen", i), 128'(done), 128'(1'b1));
      chk($sformatf("b_tab%0d_nbeats", i), 128'(nb), 128'(vb[i].nb));
    end

    // 8:2 random traffic against the queue model
    @(posedge clk); #1;
    b_drive(1'b0, '0, '0, '0, '0, '0);
    hold = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (!hold) begin
        tm = 8'h00;
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(0, 3) != 0) tm[g*2 +: 2] = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 7) == 0) tm = 8'h00;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        meta = 16'($urandom);
        b_drive(($urandom_range(0, 9) < 6), tm, r1, r2, r3, meta);
      end
      b_if.out_ready = ($urandom_range(0, 9) < 7);
      if (c >= 1150) begin
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
      end
      @(negedge clk);
      exp_ir = (bq.size() == 0) || (b_if.out_ready && bq.size() == 1);
      chk("b_rnd_in_ready", 128'(b_if.in_ready), 128'(exp_ir));
      chk("b_rnd_out_valid", 128'(b_if.out_valid), 128'(bq.size() != 0));
      if (bq.size() != 0) chk("b_rnd_beat", 128'(b_act()), 128'(bq[0]));
      fire_in = b_if.in_valid && exp_ir;
      if (bq.size() != 0 && b_if.out_ready) void'(bq.pop_front());
      if (fire_in) b_push(b_if.in_tmask, b_if.in_rs1_data, b_if.in_rs2_data,
                          b_if.in_rs3_data, b_if.in_meta);
      hold = b_if.in_valid && !fire_in;
    end
    chk("b_rnd_drained", 128'(bq.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_operands_serializer.md
Name: vx_operands_serializer

Overview:
- Next-generation operand stage between the operand collector and narrow execute units (SFU, FPU when it has fewer lanes than the warp).
- Accepts one full-width operand packet (NUM_LANES_IN threads) per handshake.
- Emits it as NUM_LANES_IN/NUM_LANES_OUT consecutive narrow beats, each tagged with a packet index and start/end markers.
- Registered, valid/ready on both sides, back-to-back capable.

Parameters:
- NUM_LANES_IN, `NUM_THREADS: thread lanes per input packet.
- NUM_LANES_OUT, 1: lanes per output beat. Must divide NUM_LANES_IN; elaboration error otherwise.
- DATA_W, `XLEN: width of one operand lane.
- META_W, 64: width of opaque per-packet sideband (uuid, wis, PC, op fields, imm, rd, flags), passed unchanged.
- NUM_PIDS, NUM_LANES_IN/NUM_LANES_OUT: derived localparam.
- PID_W, max(1,$clog2(NUM_PIDS)): derived localparam.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input packet valid.
- in_tmask  in  NUM_LANES_IN  thread mask.
- in_rs1_data  in  NUM_LANES_IN*DATA_W  operand 1, lane-major.
- in_rs2_data  in  NUM_LANES_IN*DATA_W  operand 2.
- in_rs3_data  in  NUM_LANES_IN*DATA_W  operand 3.
- in_meta  in  META_W  sideband.
- in_ready  out  1  packet accepted when in_valid&in_ready.
- out_valid  out  1  beat valid.
- out_tmask  out  NUM_LANES_OUT  mask slice for this beat.
- out_rs1_data, out_rs2_data, out_rs3_data  out  NUM_LANES_OUT*DATA_W  operand slices.
- out_meta  out  META_W  held copy of in_meta.
- out_pid  out  PID_W  group index of this beat.
- out_sop  out  1  first beat of packet.
- out_eop  out  1  last beat of packet.
- out_ready  in  1  beat consumed when out_valid&out_ready.

Behaviour:
- Reset (reset=0, asynchronous): valid_q=0, pid_q=0, out_sop/out_eop=0.
  - Data/meta registers are not reset; contents are don't-care while out_valid=0.
  - Outputs: out_valid=0, in_ready=1.
- Reset asserted mid-packet: remaining beats are discarded; no partial replay after release.
- State:
  - IDLE (valid_q=0).
  - BUSY (valid_q=1, holding packet, current pid_q).
- Outputs are slices of the held packet:
  - lanes [pid_q*NUM_LANES_OUT +: NUM_LANES_OUT].
  - out_sop=1 when pid_q equals the first emitted group.
  - out_eop=1 when pid_q is the last emitted group.
- in_ready = ~valid_q | (out_ready & out_eop). It is combinational from out_ready; no combinational path from in_valid to out_*.
- Accept: packet latched, valid_q=1, pid_q=first group. out_valid rises the cycle after accept (latency 1).
- Beat consumed, not eop: pid_q advances to next group (+1, or next non-empty per feature).
- Beat consumed, eop:
  - New packet accepted in the same cycle: load it; no bubble.
  - Otherwise: go IDLE.
- out_valid=1 with out_ready=0: all outputs held stable.
- NUM_PIDS=1: pure one-deep pipeline register; pid=0, sop=eop=1 every beat; full throughput.
- Throughput: one beat per cycle; packet occupies NUM_PIDS (or fewer) cycles.

Optional Feature:
- Macro: VX_OPERANDS_SKIP_EMPTY_EN.
- Defined:
  - Groups whose in_tmask slice is all-zero are skipped.
  - First group = lowest non-zero group; next = lowest non-zero group above pid_q; eop = no non-zero group above pid_q.
  - All-zero tmask: single beat, pid 0, sop=eop=1, out_tmask=0.
- Undefined:
  - Every group 0..NUM_PIDS-1 is emitted in order.
  - eop when pid_q==NUM_PIDS-1.

Decomposition:
- VX_gpu_pkg additions: NUM_PIDS/PID_W helper function. Existing sideband fields are not duplicated.
- One sub-module, vx_operands_group_scan: combinational priority scan over per-group any-mask. Produces first, next-after(pid) and is-last. Used only when VX_OPERANDS_SKIP_EMPTY_EN is defined.

Test Plan:
- IN=4, OUT=1, tmask=4'b1111, out_ready=1: beats pid 0,1,2,3 on consecutive cycles; sop on pid0, eop on pid3; rs1 lane k matches input lane k.
- Same packet with a second packet pending and out_ready=1: in_ready=1 in the pid3 cycle; second packet's pid0 appears the next cycle with no bubble.
- Skip enabled, IN=8, OUT=2, tmask=8'b0011_0000: single beat pid=2, sop=eop=1, out_tmask=2'b11.
- Skip enabled, tmask=0: one beat pid 0, out_tmask=0, sop=eop=1. Skip disabled: 4 beats, all with zero mask.
- out_ready toggled 1,0,0,1 during BUSY: outputs frozen while low; no beat lost or duplicated.
- reset driven low during pid=1 of a 4-beat packet: out_valid=0 and in_ready=1 immediately. After release, a new packet starts at pid 0.
